// File: rtl/mips_defs_pkg.sv
// Shared definitions for the pipelined MIPS core: widths, link register and
// encodings of the EX-stage destination select and ALU operations.
package mips_defs;

   localparam int DATA_W  = 32;
   localparam int REG_AW  = 5;
   localparam int ALUOP_W = 4;
   localparam int RA_ADDR = 31;

   typedef enum logic [1:0] {
      REGDST_RT  = 2'd0,
      REGDST_RD  = 2'd1,
      REGDST_RA  = 2'd2,
      REGDST_ILL = 2'd3
   } regdst_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11
   } alu_op_e;

   function automatic logic regdst_legal(input logic [1:0] sel);
      return sel != REGDST_ILL;
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection: a load in EX whose target is read by the
// instruction in ID forces a one-cycle stall. Purely combinational.
module load_use_detect
   import mips_defs::*;
#(
   parameter int REG_AW = mips_defs::REG_AW
) (
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rt,
   output logic              stall
);

   logic rs_match;
   logic rt_match;

   assign rs_match = (ex_rt == id_rs);
   assign rt_match = id_uses_rt & (ex_rt == id_rt);

   // $0 is hardwired, so a load into it never produces a usable hazard.
   assign stall = ~flush & id_valid & ex_valid & ex_mem_read
                & (ex_rt != '0) & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields from ID, inserts bubbles on
// flush/stall/invalid, and counts load-use stall cycles (saturating).
module id_ex_stage #(
   parameter int DATA_W  = mips_defs::DATA_W,
   parameter int REG_AW  = mips_defs::REG_AW,
   parameter int ALUOP_W = mips_defs::ALUOP_W,
   parameter int RA_ADDR = mips_defs::RA_ADDR,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [REG_AW-1:0]  id_rs,
   input  logic [REG_AW-1:0]  id_rt,
   input  logic [REG_AW-1:0]  id_rd,
   input  logic               id_uses_rt,
   input  logic [1:0]         id_regdst,
   input  logic               id_reg_write,
   input  logic               id_mem_read,
   input  logic               id_mem_write,
   input  logic               id_mem_to_reg,
   input  logic               id_alu_src,
   input  logic [ALUOP_W-1:0] id_alu_op,
   input  logic [DATA_W-1:0]  id_rdata1,
   input  logic [DATA_W-1:0]  id_rdata2,
   input  logic [DATA_W-1:0]  id_imm,
   input  logic               flush,
   output logic               stall,
   output logic               ex_valid,
   output logic [REG_AW-1:0]  ex_rs,
   output logic [REG_AW-1:0]  ex_rt,
   output logic [REG_AW-1:0]  ex_rd,
   output logic [REG_AW-1:0]  ex_ra,
   output logic [1:0]         ex_regdst,
   output logic               ex_reg_write,
   output logic               ex_mem_read,
   output logic               ex_mem_write,
   output logic               ex_mem_to_reg,
   output logic               ex_alu_src,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic [DATA_W-1:0]  ex_rdata1,
   output logic [DATA_W-1:0]  ex_rdata2,
   output logic [DATA_W-1:0]  ex_imm,
   output logic [CNT_W-1:0]   stall_count
);

   import mips_defs::*;

   logic hazard;
   logic bubble;
   logic sel_ok;

   load_use_detect #(
      .REG_AW(REG_AW)
   ) u_load_use_detect (
      .flush      (flush),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .ex_valid   (ex_valid),
      .ex_mem_read(ex_mem_read),
      .ex_rt      (ex_rt),
      .stall      (hazard)
   );

   assign stall  = hazard;
   assign bubble = flush | hazard | ~id_valid;
   assign sel_ok = regdst_legal(id_regdst);
   assign ex_ra  = REG_AW'(RA_ADDR);

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         ex_rs         <= '0;
         ex_rt         <= '0;
         ex_rd         <= '0;
         ex_regdst     <= REGDST_RT;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         ex_alu_src    <= 1'b0;
         ex_alu_op     <= '0;
         ex_rdata1     <= '0;
         ex_rdata2     <= '0;
         ex_imm        <= '0;
         stall_count   <= '0;
      end else begin
         if (hazard && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
         end
         if (bubble) begin
            ex_valid      <= 1'b0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_regdst     <= REGDST_RT;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_alu_op     <= '0;
            ex_rdata1     <= '0;
            ex_rdata2     <= '0;
            ex_imm        <= '0;
         end else begin
            ex_valid      <= 1'b1;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rd         <= id_rd;
            // An illegal select degrades to a harmless non-writing rt-form op.
            ex_regdst     <= sel_ok ? id_regdst : REGDST_RT;
            ex_reg_write  <= id_reg_write & sel_ok;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_alu_src    <= id_alu_src;
            ex_alu_op     <= id_alu_op;
            ex_rdata1     <= id_rdata1;
            ex_rdata2     <= id_rdata2;
            ex_imm        <= id_imm;
         end
      end
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the pipelined MIPS core.
- Latches decoded fields, control and operands from ID.
- Presents the three destination-register candidates and the 2-bit RegDst select to the EX-stage 3:1 destination mux (sel 0=rt, 1=rd, 2=ra).
- Generates the stall that freezes PC and IF/ID, and inserts bubbles on stall or flush.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_AW, 5, register address width
- ALUOP_W, 4, ALU opcode width
- RA_ADDR, 31, link register address driven on ex_ra
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_AW  source reg 1
- id_rt  in  REG_AW  source reg 2 / I-type dest
- id_rd  in  REG_AW  R-type dest
- id_uses_rt  in  1  instruction reads rt as source
- id_regdst  in  2  dest select: 0 rt, 1 rd, 2 ra, 3 illegal
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src  in  1 each  control
- id_alu_op  in  ALUOP_W  ALU operation
- id_rdata1, id_rdata2, id_imm  in  DATA_W each  operands / sign-extended immediate
- flush  in  1  squash ID instruction (taken branch/jump)
- stall  out  1  combinational: hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_rs, ex_rt, ex_rd  out  REG_AW  registered addresses (ex_rt/ex_rd feed mux in1/in2)
- ex_ra  out  REG_AW  constant RA_ADDR (mux in3)
- ex_regdst  out  2  mux sel
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  out  1 each
- ex_alu_op  out  ALUOP_W
- ex_rdata1, ex_rdata2, ex_imm  out  DATA_W
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset: synchronous, active-high. On a clk edge with rst=1, all registered outputs become 0 and stall_count becomes 0. ex_ra stays RA_ADDR. Reset mid-stall discards the pending hazard; stall is 0 the cycle after reset, since ex_valid=0.
- Hazard (combinational): stall = ~flush & id_valid & ex_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- Per-edge update, priority order:
  - rst: clear everything.
  - flush | stall | ~id_valid: insert bubble. ex_valid, all control, ex_regdst, addresses and data go to 0.
  - Otherwise capture all id_* fields, with ex_valid=1. Latency is 1 cycle.
- Illegal RegDst: id_regdst==3 is captured as ex_regdst=0 with ex_reg_write=0; the other fields are captured normally.
- Flush and stall in the same cycle: flush wins, stall output is 0, one bubble is inserted.
- Stall duration: exactly one cycle per load-use pair. The next cycle EX holds a bubble, so stall deasserts and the held ID instruction is captured.
- Register $0: a load targeting $0 never stalls.
- stall_count increments on each edge where stall=1 and rst=0. It saturates at all-ones with no wrap.
- The block contains no other state; no FSM beyond the valid bit.

Decomposition:
- Shared package/header `mips_defs`:
  - REGDST_RT=0, REGDST_RD=1, REGDST_RA=2
  - ALU op codes
  - RA_ADDR, DATA_W, REG_AW
- One sub-module: `load_use_detect`, the combinational stall equation, reused by the verification model.
- The pipeline register itself stays in `id_ex_stage`.

Test Plan:
- Reset mid-stream: capture a valid instruction, then assert rst for 1 cycle -> next cycle ex_valid=0, all control 0, stall_count=0, ex_ra=31.
- Normal capture: id_rt=1, id_rd=2, id_regdst=1, id_reg_write=1, id_rdata1=0x0000_00AA -> next edge ex_rt=1, ex_rd=2, ex_regdst=1, ex_rdata1=0xAA, stall=0.
- Load-use on rs: EX holds lw with ex_rt=8; ID has id_rs=8 -> stall=1 for exactly 1 cycle, EX gets a bubble, the following edge captures the ID instruction, stall_count=1.
- Load-use on $0 and rt not used: ex_rt=0 with id_rs=0 -> stall=0. Also ex_rt=9 with id_rt=9 and id_uses_rt=0 -> stall=0.
- Flush during hazard: stall condition true and flush=1 -> stall=0, bubble inserted, stall_count unchanged.
- Illegal select and saturation: id_regdst=3, id_reg_write=1 -> ex_regdst=0, ex_reg_write=0. With CNT_W=2, 5 stalls -> stall_count=3.
